// File: rtl/div_scheduler.sv
// div_scheduler: round-robin arbiter that shares one fixed-latency 32-bit
// divider among NUM_REQ requesters and returns q/r on one response channel.
// Divide-by-zero requests are answered locally (q=all ones, r=dividend).
// Optional statistics counters are enabled by defining DIV_SCHED_STATS_EN.
module div_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DIV_LATENCY = 33,
    parameter int unsigned ID_W        = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_q,
    output logic [31:0]            resp_r,
    output logic                   resp_dbz,
    output logic                   div_start,
    output logic [31:0]            div_a,
    output logic [31:0]            div_b,
    input  logic [31:0]            div_q,
    input  logic [31:0]            div_r,
    output logic                   busy
`ifdef DIV_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_ops,
    output logic [15:0]            stat_dbz,
    output logic [31:0]            stat_stall
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    lat_id;
    logic [CNT_W-1:0]    cnt;

    logic                found;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    pos;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                accept;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            pos = IDX_W'((int'(ptr) + i) % int'(NUM_REQ));
            if (!found && req_valid[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == IDX_W'(i)) begin
                sel_a = req_a[DATA_W*i +: DATA_W];
                sel_b = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Grant is combinational in IDLE so the handshake completes in one cycle.
    always_comb begin
        accept    = (state == IDLE) && found && !reset;
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Sequencer: IDLE -> (ISSUE -> WAIT ->) RESP -> IDLE, all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            lat_id     <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_dbz   <= 1'b0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr    <= winner;
                        lat_id <= winner;
                        busy   <= 1'b1;
                        if (sel_b == '0) begin
                            // Answered locally; the divider is never started.
                            resp_id    <= ID_W'(winner);
                            resp_q     <= '1;
                            resp_r     <= sel_a;
                            resp_dbz   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            div_a     <= sel_a;
                            div_b     <= sel_b;
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start <= 1'b0;
                    cnt       <= CNT_W'(DIV_LATENCY - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_id    <= ID_W'(lat_id);
                        resp_q     <= div_q;
                        resp_r     <= div_r;
                        resp_dbz   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DIV_SCHED_STATS_EN
    // Free-running statistics: completed responses, dbz responses, stalled cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_dbz   <= '0;
            stat_stall <= '0;
        end else begin
            if (resp_valid && resp_ready) begin
                stat_ops <= stat_ops + 32'd1;
                if (resp_dbz) begin
                    stat_dbz <= stat_dbz + 16'd1;
                end
            end
            if (resp_valid && !resp_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: directed and randomized checks of div_scheduler against a
// transaction-level reference model and a fixed-latency divider model.
module tb_div_scheduler;

    localparam int N  = 4;
    localparam int L  = 33;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IW-1:0]     resp_id;
    logic [31:0]       resp_q;
    logic [31:0]       resp_r;
    logic              resp_dbz;
    logic              div_start;
    logic [31:0]       div_a;
    logic [31:0]       div_b;
    logic [31:0]       div_q = '0;
    logic [31:0]       div_r = '0;
    logic              busy;
`ifdef DIV_SCHED_STATS_EN
    logic [31:0]       stat_ops;
    logic [15:0]       stat_dbz;
    logic [31:0]       stat_stall;
`endif

    div_scheduler #(.NUM_REQ(N), .DIV_LATENCY(L), .ID_W(IW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .resp_r     (resp_r),
        .resp_dbz   (resp_dbz),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (div_q),
        .div_r      (div_r),
        .busy       (busy)
`ifdef DIV_SCHED_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_dbz   (stat_dbz),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, required event not seen (cycle %0d)", name, cyc);
    endtask

    // Requester operand storage, packed onto the bus by apply().
    logic [31:0] ra [N];
    logic [31:0] rb [N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = ra[i];
            req_b[32*i +: 32] = rb[i];
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Divider model: results valid only in the cycle DIV_LATENCY after the start pulse.
    logic [31:0] dm_a, dm_b;
    int          dm_rem = 0;
    bit          dm_act = 1'b0;
    always @(negedge clock) begin
        if (div_start) begin
            dm_a = div_a; dm_b = div_b; dm_rem = L; dm_act = 1'b1;
        end else if (dm_act) begin
            if (dm_rem == 0) dm_act = 1'b0;
            else dm_rem--;
        end
        if (dm_act && dm_rem == 0 && dm_b != 0) begin
            div_q = dm_a / dm_b;
            div_r = dm_a % dm_b;
        end else begin
            div_q = $urandom;
            div_r = $urandom;
        end
    end

    // Reference model: one job at a time, outputs derived from its accept cycle.
    bit           chk_en   = 1'b0;
    logic [N-1:0] acc_mask = '0;
    bit           m_act    = 1'b0;
    int           m_t      = 0;
    int           m_last   = N - 1;
    int           m_id     = 0;
    logic [31:0]  m_a, m_b, m_q, m_r;
    bit           m_dbz    = 1'b0;
    logic [31:0]  st_ops   = '0;
    logic [15:0]  st_dbz   = '0;
    logic [31:0]  st_stall = '0;

    always @(negedge clock) begin
        int           win;
        int           age;
        int           idx;
        logic [N-1:0] e_rr;
        bit           e_busy, e_rv, e_ds;
        win = -1; age = 0; e_rr = '0; e_busy = 1'b0; e_rv = 1'b0; e_ds = 1'b0;
        if (!m_act) begin
            if (!reset) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) e_rr[win] = 1'b1;
        end else begin
            age    = cyc - m_t;
            e_busy = 1'b1;
            e_ds   = !m_dbz && (age == 1);
            e_rv   = m_dbz || (age >= L + 2);
        end
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(e_rr));
            check("busy", 64'(busy), 64'(e_busy));
            check("resp_valid", 64'(resp_valid), 64'(e_rv));
            check("div_start", 64'(div_start), 64'(e_ds));
            if (e_rv) begin
                check("resp_id", 64'(resp_id), 64'(m_id));
                check("resp_q", 64'(resp_q), 64'(m_q));
                check("resp_r", 64'(resp_r), 64'(m_r));
                check("resp_dbz", 64'(resp_dbz), 64'(m_dbz));
            end
            if (m_act && !m_dbz && age >= 1 && age <= L + 1) begin
                check("div_a", 64'(div_a), 64'(m_a));
                check("div_b", 64'(div_b), 64'(m_b));
            end
`ifdef DIV_SCHED_STATS_EN
            check("stat_ops", 64'(stat_ops), 64'(st_ops));
            check("stat_dbz", 64'(stat_dbz), 64'(st_dbz));
            check("stat_stall", 64'(stat_stall), 64'(st_stall));
`endif
        end
        if (reset) begin
            m_act = 1'b0; m_last = N - 1;
            st_ops = '0; st_dbz = '0; st_stall = '0;
        end else begin
            if (!m_act) begin
                if (win >= 0) begin
                    m_act = 1'b1; m_t = cyc; m_id = win; m_last = win;
                    m_a = req_a[32*win +: 32];
                    m_b = req_b[32*win +: 32];
                    m_dbz = (m_b == 32'd0);
                    if (m_dbz) begin
                        m_q = 32'hFFFF_FFFF; m_r = m_a;
                    end else begin
                        m_q = m_a / m_b; m_r = m_a % m_b;
                    end
                    acc_mask[win] = 1'b1;
                end
            end else if (e_rv && resp_ready) begin
                m_act = 1'b0;
                st_ops = st_ops + 32'd1;
                if (m_dbz) st_dbz = st_dbz + 16'd1;
            end
            if (e_rv && !resp_ready) st_stall = st_stall + 32'd1;
        end
    end

    task automatic drop_granted();
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                acc_mask[i]  = 1'b0;
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; apply();
        step(); step();
        reset = 1'b0; acc_mask = '0;
    endtask

    // Single request with resp_ready held high; reports timing and the response.
    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int ds_n, output int ds_at,
                           output logic [31:0] q, output logic [31:0] r,
                           output int rid, output bit dbz);
        int t0;
        logic [N-1:0] oh;
        oh = '0; oh[id] = 1'b1;
        lat = -1; ds_n = 0; ds_at = -1; q = '0; r = '0; rid = -1; dbz = 1'b0;
        req_valid[id] = 1'b1; ra[id] = a; rb[id] = b; resp_ready = 1'b1; apply();
        #1;
        t0 = cyc;
        check("grant_onehot", 64'(req_ready), 64'(oh));
        for (int n = 0; n < 100 && lat < 0; n++) begin
            step(); drop_granted(); apply();
            if (div_start) begin ds_n++; ds_at = cyc - t0; end
            if (resp_valid) begin
                lat = cyc - t0; q = resp_q; r = resp_r; rid = int'(resp_id); dbz = resp_dbz;
            end
        end
        if (lat < 0) fail("resp_timeout");
        step();
    endtask

    task automatic drain(output bit got, output int gid, output logic [31:0] gq, output logic [31:0] gr);
        bit done;
        got = 1'b0; gid = -1; gq = '0; gr = '0; done = 1'b0;
        resp_ready = 1'b1; apply();
        for (int n = 0; n < 2000 && !done; n++) begin
            step(); drop_granted(); apply();
            if (resp_valid && !got) begin
                got = 1'b1; gid = int'(resp_id); gq = resp_q; gr = resp_r;
            end
            if (req_valid == '0 && !busy && acc_mask == '0) done = 1'b1;
        end
        if (!done) fail("drain_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ds_n, ds_at, rid, gid, ng;
        logic [31:0] q, r, gq, gr;
        bit dbz, got;
        int order [6];
        int exp_order [6];
        int t0;
        logic [N-1:0] g;
        exp_order = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end

        // Reset state
        reset = 1'b1; apply();
        step(); step(); step();
        reset = 1'b0; acc_mask = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_q", 64'(resp_q), 64'd0);
        check("rst_resp_r", 64'(resp_r), 64'd0);
        check("rst_resp_dbz", 64'(resp_dbz), 64'd0);
        check("rst_div_a", 64'(div_a), 64'd0);
        check("rst_div_b", 64'(div_b), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        chk_en = 1'b1;

        // 100 / 7 from requester 0
        run_one(0, 32'd100, 32'd7, lat, ds_n, ds_at, q, r, rid, dbz);
        check("t1_latency", 64'(lat), 64'd35);
        check("t1_start_count", 64'(ds_n), 64'd1);
        check("t1_start_at", 64'(ds_at), 64'd1);
        check("t1_q", 64'(q), 64'd14);
        check("t1_r", 64'(r), 64'd2);
        check("t1_id", 64'(rid), 64'd0);
        check("t1_dbz", 64'(dbz), 64'd0);

        // 5 / 0 from requester 2
        run_one(2, 32'd5, 32'd0, lat, ds_n, ds_at, q, r, rid, dbz);
        check("t2_latency", 64'(lat), 64'd1);
        check("t2_start_count", 64'(ds_n), 64'd0);
        check("t2_q", 64'(q), 64'hFFFF_FFFF);
        check("t2_r", 64'(r), 64'd5);
        check("t2_id", 64'(rid), 64'd2);
        check("t2_dbz", 64'(dbz), 64'd1);

        // Requesters 0, 1, 3 valid continuously from reset
        reset = 1'b1;
        req_valid = 4'b1011;
        for (int i = 0; i < N; i++) begin ra[i] = $urandom; rb[i] = $urandom_range(1, 1000); end
        apply(); step(); step();
        reset = 1'b0; acc_mask = '0; resp_ready = 1'b1;
        ng = 0;
        for (int n = 0; n < 400 && ng < 6; n++) begin
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    acc_mask[i] = 1'b0; ra[i] = $urandom; rb[i] = $urandom_range(1, 1000);
                end
            end
            apply(); #1;
            check("t3_onehot0", 64'($onehot0(req_ready)), 64'd1);
            g = req_ready & req_valid;
            for (int i = 0; i < N; i++) begin
                if (g[i] && ng < 6) begin order[ng] = i; ng++; end
            end
            step();
        end
        if (ng < 6) fail("t3_grants");
        for (int k = 0; k < ng; k++) check($sformatf("t3_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
        req_valid = '0; apply();
        drain(got, gid, gq, gr);

        // Back-pressure: resp_ready low for 10 cycles with another requester waiting
        do_reset();
        resp_ready = 1'b0;
        req_valid[0] = 1'b1; ra[0] = 32'hFFFF_FFFF; rb[0] = 32'd16;
        req_valid[1] = 1'b1; ra[1] = 32'd50; rb[1] = 32'd3;
        apply();
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            step();
            for (int i = 0; i < N; i++) if (acc_mask[i] && i == 0) begin acc_mask[i] = 1'b0; req_valid[i] = 1'b0; end
            apply();
            if (resp_valid) got = 1'b1;
        end
        if (!got) fail("t4_resp_timeout");
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t4_resp_valid", 64'(resp_valid), 64'd1);
            check("t4_q", 64'(resp_q), 64'h0FFF_FFFF);
            check("t4_r", 64'(resp_r), 64'd15);
            check("t4_id", 64'(resp_id), 64'd0);
            check("t4_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 1'b1; apply();
        step();
`ifdef DIV_SCHED_STATS_EN
        check("t4_stat_stall", 64'(stat_stall), 64'd10);
`endif
        drain(got, gid, gq, gr);

        // Reset while waiting on the divider (cnt==12)
        do_reset();
        resp_ready = 1'b1;
        req_valid[2] = 1'b1; ra[2] = 32'd123456; rb[2] = 32'd789; apply();
        #1;
        t0 = cyc;
        step(); drop_granted(); apply();
        for (int n = 0; n < 100 && cyc < t0 + 22; n++) step();
        check("t5_busy_before", 64'(busy), 64'd1);
        reset = 1'b1; apply();
        step();
        reset = 1'b0; acc_mask = '0;
        check("t5_busy_after", 64'(busy), 64'd0);
        check("t5_resp_valid_after", 64'(resp_valid), 64'd0);
        check("t5_resp_q_after", 64'(resp_q), 64'd0);
        req_valid[0] = 1'b1; ra[0] = 32'd1000; rb[0] = 32'd10;
        req_valid[3] = 1'b1; ra[3] = 32'd9;    rb[3] = 32'd4;
        apply(); #1;
        check("t5_grant_first", 64'(req_ready), 64'b0001);
        drain(got, gid, gq, gr);
        check("t5_got", 64'(got), 64'd1);
        check("t5_id", 64'(gid), 64'd0);
        check("t5_q", 64'(gq), 64'd100);
        check("t5_r", 64'(gr), 64'd0);

        // Three normal and two divide-by-zero requests, all consumed
        do_reset();
        run_one(0, 32'd77, 32'd5, lat, ds_n, ds_at, q, r, rid, dbz);
        run_one(1, 32'd8, 32'd0, lat, ds_n, ds_at, q, r, rid, dbz);
        run_one(2, 32'd1000, 32'd33, lat, ds_n, ds_at, q, r, rid, dbz);
        run_one(3, 32'd0, 32'd0, lat, ds_n, ds_at, q, r, rid, dbz);
        run_one(0, 32'd12345, 32'd1, lat, ds_n, ds_at, q, r, rid, dbz);
        check("t6_last_q", 64'(q), 64'd12345);
`ifdef DIV_SCHED_STATS_EN
        check("t6_stat_ops", 64'(stat_ops), 64'd5);
        check("t6_stat_dbz", 64'(stat_dbz), 64'd2);
`endif

        // Randomized traffic checked cycle by cycle against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    acc_mask[i] = 1'b0; req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    ra[i] = $urandom;
                    if ($urandom_range(0, 4) == 0) rb[i] = 32'd0;
                    else if ($urandom_range(0, 1) == 0) rb[i] = $urandom_range(1, 1000);
                    else rb[i] = $urandom;
                end
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            apply();
        end
        req_valid = '0; apply();
        drain(got, gid, gq, gr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
